// File: rtl/mod_check_pkg.sv
// mod_check_pkg: shared state encoding, successor helper and counter defaults for the modulo-N sequence checker.
package mod_check_pkg;
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
    localparam int DEF_CW = 8;
    localparam int DEF_SAT = (1 << DEF_CW) - 1;
    function automatic int succ(input int x, input int m);
        return (x == m - 1) ? 0 : x + 1;
    endfunction
endpackage

// File: rtl/mod_count_checker_if.sv
// mod_count_checker_if: sampled count bus plus the checker's status and statistics outputs.
interface mod_count_checker_if #(
    parameter int W  = 3,
    parameter int CW = 8
);
    logic          valid;
    logic [W-1:0]  count_in;
    logic          locked;
    logic [W-1:0]  expected;
    logic          err_pulse;
    logic          range_err;
    logic          wrap_pulse;
    logic [CW-1:0] err_count;
    logic [CW-1:0] wrap_count;
    modport master (
        output valid, count_in,
        input  locked, expected, err_pulse, range_err, wrap_pulse, err_count, wrap_count
    );
    modport slave (
        input  valid, count_in,
        output locked, expected, err_pulse, range_err, wrap_pulse, err_count, wrap_count
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: CW-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count
);
    always_ff @(posedge clk)
        count <= clr ? '0 : (inc && !(&count)) ? count + 1'b1 : count;
endmodule

// File: rtl/mod_count_checker.sv
// mod_count_checker: locks onto a wrapping 0..MOD-1 count stream and flags skips, repeats and out-of-range samples.
module mod_count_checker
    import mod_check_pkg::*;
#(
    parameter int MOD      = 5,
    parameter int W        = 3,
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2,
    parameter int CW       = DEF_CW
) (
    input logic clk,
    input logic rst,
    mod_count_checker_if.slave bus
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);

    state_t        state;
    logic [W-1:0]  prev;
    logic [GW-1:0] good_cnt;
    logic [BW-1:0] bad_cnt;
    logic          in_range, match, lost, err_inc, wrap_inc;
    logic [W-1:0]  sp, nprev, nexp;
    logic [CW-1:0] err_count, wrap_count;

    // An out-of-range sample while locked stands in for the value that should have arrived.
    always_comb begin
        in_range = int'(bus.count_in) < MOD;
        sp       = W'(succ(int'(prev), MOD));
        match    = bus.count_in == sp;
        nprev    = in_range ? bus.count_in : sp;
        nexp     = W'(succ(int'(nprev), MOD));
        lost     = int'(bad_cnt) + 1 == LOSS_CNT;
        err_inc  = bus.valid && state == LOCKED && !match;
        wrap_inc = bus.valid && state == LOCKED && match && int'(prev) == MOD - 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            prev           <= '0;
            good_cnt       <= '0;
            bad_cnt        <= '0;
            bus.locked     <= 1'b0;
            bus.expected   <= '0;
            bus.err_pulse  <= 1'b0;
            bus.range_err  <= 1'b0;
            bus.wrap_pulse <= 1'b0;
        end else begin
            bus.err_pulse  <= err_inc;
            bus.wrap_pulse <= wrap_inc;
            bus.range_err  <= bus.valid && !in_range;
            if (bus.valid) begin
                case (state)
                    IDLE: if (in_range) begin
                        state        <= ACQUIRE;
                        prev         <= nprev;
                        good_cnt     <= GW'(1);
                        bus.expected <= nexp;
                    end
                    ACQUIRE: if (!in_range) begin
                        state        <= IDLE;
                        prev         <= '0;
                        good_cnt     <= '0;
                        bus.expected <= '0;
                    end else begin
                        prev         <= nprev;
                        bus.expected <= nexp;
                        good_cnt     <= match ? good_cnt + 1'b1 : GW'(1);
                        if (match && int'(good_cnt) + 1 == LOCK_CNT) begin
                            state      <= LOCKED;
                            bad_cnt    <= '0;
                            bus.locked <= 1'b1;
                        end
                    end
                    LOCKED: if (match || !lost) begin
                        prev         <= nprev;
                        bus.expected <= nexp;
                        bad_cnt      <= match ? '0 : bad_cnt + 1'b1;
                    end else begin
                        state        <= in_range ? ACQUIRE : IDLE;
                        prev         <= in_range ? nprev : '0;
                        good_cnt     <= in_range ? GW'(1) : '0;
                        bus.expected <= in_range ? nexp : '0;
                        bad_cnt      <= '0;
                        bus.locked   <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    sat_counter #(.CW(CW)) u_err_cnt (
        .clk  (clk),
        .clr  (rst),
        .inc  (err_inc),
        .count(err_count)
    );

    sat_counter #(.CW(CW)) u_wrap_cnt (
        .clk  (clk),
        .clr  (rst),
        .inc  (wrap_inc),
        .count(wrap_count)
    );

    assign bus.err_count  = err_count;
    assign bus.wrap_count = wrap_count;
endmodule

// File: tb/tb_mod_count_checker.sv
// tb_mod_count_checker: directed scenarios plus a random stream, all checked against a run-length reference model.
module tb_mod_count_checker;
    localparam int MOD = 5, W = 3, LOCK_CNT = 3, LOSS_CNT = 2, CW = 8;
    localparam int SAT = (1 << CW) - 1;
    localparam int VW = 3 * 1 + W + 1 + 2 * CW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mod_count_checker_if #(.W(W), .CW(CW)) bus ();
    mod_count_checker #(.MOD(MOD), .W(W), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CW(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: lock flag, length of the current in-sequence run, consecutive misses while locked.
    bit    m_lock;
    int    m_prev, m_run, m_miss, m_errs, m_wraps, e_exp;
    bit    e_err, e_rng, e_wrap;
    logic [VW-1:0] mdl;
    wire  [VW-1:0] obs = {bus.locked, bus.expected, bus.err_pulse, bus.range_err, bus.wrap_pulse,
                          bus.err_count, bus.wrap_count};

    task automatic model_clear();
        m_lock = 0; m_prev = 0; m_run = 0; m_miss = 0; m_errs = 0; m_wraps = 0;
        e_err = 0; e_rng = 0; e_wrap = 0; e_exp = 0;
        mdl = '0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        bus.valid = 1'b0;
        bus.count_in = '0;
        @(posedge clk);
        model_clear();
        #1;
        rst = 1'b0;
    endtask

    task automatic drive(input bit v, input int c);
        bit inr, hit;
        int nx;
        bus.valid = v;
        bus.count_in = W'(c);
        @(posedge clk);
        e_err = 0; e_rng = 0; e_wrap = 0;
        if (v) begin
            inr = c < MOD;
            nx = (m_prev + 1) % MOD;
            hit = inr && c == nx;
            e_rng = !inr;
            if (m_lock) begin
                if (hit) begin
                    if (m_prev == MOD - 1) begin
                        e_wrap = 1;
                        if (m_wraps < SAT) m_wraps++;
                    end
                    m_prev = c;
                    m_miss = 0;
                end else begin
                    e_err = 1;
                    if (m_errs < SAT) m_errs++;
                    m_prev = inr ? c : nx;
                    m_miss++;
                    if (m_miss == LOSS_CNT) begin
                        m_lock = 0;
                        m_miss = 0;
                        m_run = inr ? 1 : 0;
                    end
                end
            end else if (!inr) m_run = 0;
            else if (m_run > 0 && hit) begin
                m_run++;
                m_prev = c;
                if (m_run == LOCK_CNT) m_lock = 1;
            end else begin
                m_run = 1;
                m_prev = c;
            end
        end
        e_exp = (m_lock || m_run > 0) ? (m_prev + 1) % MOD : 0;
        mdl = {m_lock, W'(e_exp), e_err, e_rng, e_wrap, CW'(m_errs), CW'(m_wraps)};
        #1;
    endtask

    task automatic test_reset();
        do_rst();
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL reset: got %h expected 0", obs);
        end
    endtask

    task automatic test_clean();
        int s[7] = '{0, 1, 2, 3, 4, 0, 1};
        do_rst();
        foreach (s[i]) begin
            drive(1, s[i]);
            n_cmp++;
            if (obs !== mdl) begin
                n_bad++;
                $display("FAIL clean[%0d]: got %h expected %h", i, obs, mdl);
            end
        end
        n_cmp++;
        if (bus.wrap_count !== CW'(1) || bus.err_count !== '0 || bus.locked !== 1'b1) begin
            n_bad++;
            $display("FAIL clean_stats: got wrap=%0d err=%0d lock=%b expected 1/0/1",
                     bus.wrap_count, bus.err_count, bus.locked);
        end
    endtask

    task automatic test_repeat();
        int s[8] = '{0, 1, 2, 3, 1, 2, 3, 4};
        do_rst();
        foreach (s[i]) begin
            drive(1, s[i]);
            n_cmp++;
            if (obs !== mdl) begin
                n_bad++;
                $display("FAIL repeat[%0d]: got %h expected %h", i, obs, mdl);
            end
            if (i == 4) begin
                n_cmp++;
                if (bus.err_pulse !== 1'b1 || bus.locked !== 1'b1) begin
                    n_bad++;
                    $display("FAIL repeat_err: got err=%b lock=%b expected 1/1", bus.err_pulse, bus.locked);
                end
            end
        end
        n_cmp++;
        if (bus.err_count !== CW'(1)) begin
            n_bad++;
            $display("FAIL repeat_cnt: got %0d expected 1", bus.err_count);
        end
    endtask

    task automatic test_double_skip();
        int s[7] = '{0, 1, 2, 4, 1, 2, 3};
        do_rst();
        foreach (s[i]) begin
            drive(1, s[i]);
            n_cmp++;
            if (obs !== mdl) begin
                n_bad++;
                $display("FAIL skip[%0d]: got %h expected %h", i, obs, mdl);
            end
            if (i == 4) begin
                n_cmp++;
                if (bus.locked !== 1'b0 || bus.err_pulse !== 1'b1 || bus.err_count !== CW'(2)) begin
                    n_bad++;
                    $display("FAIL skip_loss: got lock=%b err=%b cnt=%0d expected 0/1/2",
                             bus.locked, bus.err_pulse, bus.err_count);
                end
            end
        end
        n_cmp++;
        if (bus.locked !== 1'b1) begin
            n_bad++;
            $display("FAIL skip_relock: got %b expected 1", bus.locked);
        end
    endtask

    task automatic test_range();
        int s[5] = '{0, 1, 2, 6, 4};
        do_rst();
        drive(1, 6);
        n_cmp++;
        if (obs !== mdl || bus.range_err !== 1'b1 || bus.expected !== '0) begin
            n_bad++;
            $display("FAIL range_idle: got %h expected %h", obs, mdl);
        end
        do_rst();
        foreach (s[i]) begin
            drive(1, s[i]);
            n_cmp++;
            if (obs !== mdl) begin
                n_bad++;
                $display("FAIL range_lock[%0d]: got %h expected %h", i, obs, mdl);
            end
            if (i == 3) begin
                n_cmp++;
                if (bus.range_err !== 1'b1 || bus.err_pulse !== 1'b1 || bus.expected !== W'(4)) begin
                    n_bad++;
                    $display("FAIL range_both: got rng=%b err=%b exp=%0d expected 1/1/4",
                             bus.range_err, bus.err_pulse, bus.expected);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int s[8] = '{0, 1, 2, 2, 3, 3, 4, 4};
        do_rst();
        foreach (s[i]) begin
            drive(1, s[i]);
            n_cmp++;
            if (obs !== mdl) begin
                n_bad++;
                $display("FAIL mid[%0d]: got %h expected %h", i, obs, mdl);
            end
        end
        n_cmp++;
        if (bus.err_count !== CW'(3) || bus.locked !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre: got cnt=%0d lock=%b expected 3/1", bus.err_count, bus.locked);
        end
        do_rst();
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL mid_rst: got %h expected 0", obs);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, $urandom_range(0, 7));
            n_cmp++;
            if (obs !== '0) begin
                n_bad++;
                $display("FAIL idle_hold[%0d]: got %h expected 0", i, obs);
            end
        end
    endtask

    task automatic test_locked_hold();
        int s[5] = '{3, 4, 0, 1, 0};
        do_rst();
        foreach (s[i]) begin
            drive(i < 4, s[i]);
            n_cmp++;
            if (obs !== mdl) begin
                n_bad++;
                $display("FAIL hold_setup[%0d]: got %h expected %h", i, obs, mdl);
            end
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, $urandom_range(0, 7));
            n_cmp++;
            if (obs !== mdl || bus.locked !== 1'b1 || bus.expected !== W'(2)) begin
                n_bad++;
                $display("FAIL hold[%0d]: got %h expected %h", i, obs, mdl);
            end
        end
    endtask

    task automatic test_saturation();
        do_rst();
        for (int i = 0; i < 3; i++) drive(1, i);
        for (int i = 0; i < 300; i++) begin
            drive(1, m_prev);
            drive(1, (m_prev + 1) % MOD);
            n_cmp++;
            if (obs !== mdl) begin
                n_bad++;
                $display("FAIL sat[%0d]: got %h expected %h", i, obs, mdl);
            end
        end
        n_cmp++;
        if (bus.err_count !== CW'(SAT) || bus.locked !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_final: got cnt=%0d lock=%b expected %0d/1", bus.err_count, bus.locked, SAT);
        end
    endtask

    task automatic test_random();
        int r, c;
        do_rst();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_rst();
            r = $urandom_range(0, 9);
            c = r < 7 ? (m_prev + 1) % MOD : r < 9 ? $urandom_range(0, MOD - 1) : $urandom_range(MOD, 7);
            drive($urandom_range(0, 3) != 0, c);
            n_cmp++;
            if (obs !== mdl) begin
                n_bad++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs, mdl);
            end
        end
    endtask

    initial begin
        bus.valid = 1'b0;
        bus.count_in = '0;
        model_clear();
        test_reset();
        test_clean();
        test_repeat();
        test_double_skip();
        test_range();
        test_reset_mid();
        test_locked_hold();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
